gpib_acceptor: RTL and testbench

GPIB_ACCEPTOR -- requirements
Module: gpib_acceptor

---
 rtl/gpib_acceptor.sv | 207 ++++++++++++++++++++
 tb/tb_gpib_acceptor.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/gpib_acceptor.sv
// GPIB acceptor handshake (AH function): synchronizes the talker lines, runs the
// three-wire handshake and presents each received byte on a valid/ready port.
// Optional ACCEPT watchdog: define GPIB_ACCEPTOR_TIMEOUT_EN.
module gpib_acceptor #(
    parameter int unsigned SETTLE         = 2,
    parameter int unsigned TIMEOUT_CYCLES = 12000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       listen,
    input  logic       dav_n,
    input  logic       eoi_n,
    input  logic       atn_n,
    input  logic [7:0] dio_n,
    output logic       nrfd_n,
    output logic       ndac_n,
    output logic [7:0] rx_data,
    output logic       rx_eoi,
    output logic       rx_atn,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       err_timeout
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RDY_WAIT = 3'd1,
        READY    = 3'd2,
        CAPTURE  = 3'd3,
        ACCEPT   = 3'd4
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    // {atn_n, eoi_n, dav_n, dio_n[7:0]}; released (all ones) out of reset
    logic [10:0] sync_meta_q;
    logic [10:0] sync_q;

    state_t      state_q,    state_d;
    logic [3:0]  settle_q,   settle_d;
    logic        nrfd_n_q,   nrfd_n_d;
    logic        ndac_n_q,   ndac_n_d;
    logic [7:0]  rx_data_q,  rx_data_d;
    logic        rx_eoi_q,   rx_eoi_d;
    logic        rx_atn_q,   rx_atn_d;
    logic        rx_valid_q, rx_valid_d;

    logic        dav_s;
    logic        eoi_s;
    logic        atn_s;
    logic [7:0]  dio_s;

`ifdef GPIB_ACCEPTOR_TIMEOUT_EN
    localparam logic [23:0] TMO_LAST = 24'(TIMEOUT_CYCLES - 1);
    logic [23:0] tmo_q, tmo_d;
    logic        err_q, err_d;
`endif

    assign dav_s = ~sync_q[8];
    assign eoi_s = ~sync_q[9];
    assign atn_s = ~sync_q[10];
    assign dio_s = ~sync_q[7:0];

    // Two-flop synchronizer for all asynchronous bus lines
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta_q <= 11'h7FF;
            sync_q      <= 11'h7FF;
        end else begin
            sync_meta_q <= {atn_n, eoi_n, dav_n, dio_n};
            sync_q      <= sync_meta_q;
        end
    end

    // Next-state, capture and handshake-line decode
    always_comb begin
        state_d    = state_q;
        settle_d   = settle_q;
        rx_data_d  = rx_data_q;
        rx_eoi_d   = rx_eoi_q;
        rx_atn_d   = rx_atn_q;
`ifdef GPIB_ACCEPTOR_TIMEOUT_EN
        tmo_d      = tmo_q;
        err_d      = 1'b0;
`endif
        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end else begin
            rx_valid_d = rx_valid_q;
        end

        if (!listen) begin
            // An unlatched byte is dropped; a byte already held stays available
            state_d  = IDLE;
            settle_d = 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = RDY_WAIT;
                end
                RDY_WAIT: begin
                    if (!rx_valid_q && !dav_s) begin
                        state_d = READY;
                    end else begin
                        state_d = RDY_WAIT;
                    end
                end
                READY: begin
                    if (dav_s) begin
                        state_d  = CAPTURE;
                        settle_d = 4'd0;
                    end else begin
                        state_d = READY;
                    end
                end
                CAPTURE: begin
                    if (!dav_s) begin
                        state_d = RDY_WAIT;
                    end else if (settle_q == SETTLE_LAST) begin
                        state_d    = ACCEPT;
                        rx_data_d  = dio_s;
                        rx_eoi_d   = eoi_s;
                        rx_atn_d   = atn_s;
                        rx_valid_d = 1'b1;
`ifdef GPIB_ACCEPTOR_TIMEOUT_EN
                        tmo_d      = 24'd0;
`endif
                    end else begin
                        settle_d = settle_q + 4'd1;
                    end
                end
                ACCEPT: begin
                    if (!dav_s) begin
                        state_d = RDY_WAIT;
`ifdef GPIB_ACCEPTOR_TIMEOUT_EN
                    end else if (tmo_q == TMO_LAST) begin
                        state_d = RDY_WAIT;
                        err_d   = 1'b1;
                    end else begin
                        tmo_d = tmo_q + 24'd1;
`else
                    end else begin
                        state_d = ACCEPT;
`endif
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Lines are decoded from the next state so they change together with it
        case (state_d)
            IDLE:     begin nrfd_n_d = 1'b1; ndac_n_d = 1'b1; end
            RDY_WAIT: begin nrfd_n_d = 1'b0; ndac_n_d = 1'b0; end
            READY:    begin nrfd_n_d = 1'b1; ndac_n_d = 1'b0; end
            CAPTURE:  begin nrfd_n_d = 1'b0; ndac_n_d = 1'b0; end
            ACCEPT:   begin nrfd_n_d = 1'b0; ndac_n_d = 1'b1; end
            default:  begin nrfd_n_d = 1'b1; ndac_n_d = 1'b1; end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            settle_q   <= 4'd0;
            nrfd_n_q   <= 1'b1;
            ndac_n_q   <= 1'b1;
            rx_data_q  <= 8'h00;
            rx_eoi_q   <= 1'b0;
            rx_atn_q   <= 1'b0;
            rx_valid_q <= 1'b0;
`ifdef GPIB_ACCEPTOR_TIMEOUT_EN
            tmo_q      <= 24'd0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            settle_q   <= settle_d;
            nrfd_n_q   <= nrfd_n_d;
            ndac_n_q   <= ndac_n_d;
            rx_data_q  <= rx_data_d;
            rx_eoi_q   <= rx_eoi_d;
            rx_atn_q   <= rx_atn_d;
            rx_valid_q <= rx_valid_d;
`ifdef GPIB_ACCEPTOR_TIMEOUT_EN
            tmo_q      <= tmo_d;
            err_q      <= err_d;
`endif
        end
    end

    assign nrfd_n   = nrfd_n_q;
    assign ndac_n   = ndac_n_q;
    assign rx_data  = rx_data_q;
    assign rx_eoi   = rx_eoi_q;
    assign rx_atn   = rx_atn_q;
    assign rx_valid = rx_valid_q;
`ifdef GPIB_ACCEPTOR_TIMEOUT_EN
    assign err_timeout = err_q;
`else
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_gpib_acceptor.sv
// Scoreboard bench for gpib_acceptor: a bus talker model issues bytes and queues
// the expected receptions; a separate monitor pops and compares on each rx pop.
module tb_gpib_acceptor;

    logic       clk = 1'b0;
    logic       rst;
    logic       listen;
    logic       dav_n;
    logic       eoi_n;
    logic       atn_n;
    logic [7:0] dio_n;
    logic       nrfd_n;
    logic       ndac_n;
    logic [7:0] rx_data;
    logic       rx_eoi;
    logic       rx_atn;
    logic       rx_valid;
    logic       rx_ready;
    logic       err_timeout;

    typedef struct packed {
        logic [7:0] data;
        logic       eoi;
        logic       atn;
    } rx_t;

    rx_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  n_rx     = 0;

    always #5 clk = ~clk;

    gpib_acceptor #(.SETTLE(2), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .listen(listen),
        .dav_n(dav_n), .eoi_n(eoi_n), .atn_n(atn_n), .dio_n(dio_n),
        .nrfd_n(nrfd_n), .ndac_n(ndac_n),
        .rx_data(rx_data), .rx_eoi(rx_eoi), .rx_atn(rx_atn),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .err_timeout(err_timeout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bounded wait for a given {nrfd_n, ndac_n} bus pattern
    task automatic wait_bus(input string name, input logic nrfd, input logic ndac);
        bit ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (nrfd_n === nrfd && ndac_n === ndac) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: bus %b%b never reached expected %b%b", name, nrfd_n, ndac_n, nrfd, ndac);
        end
    endtask

    task automatic send_byte(input logic [7:0] dio, input logic eoi, input logic atn);
        wait_bus("talk_ready", 1'b1, 1'b0);
        dio_n = dio;
        eoi_n = eoi;
        atn_n = atn;
        exp_q.push_back('{data: ~dio, eoi: ~eoi, atn: ~atn});
        dav_n = 1'b0;
        wait_bus("talk_capture", 1'b0, 1'b0);
        wait_bus("talk_accept", 1'b0, 1'b1);
        dav_n = 1'b1;
        dio_n = 8'hFF;
        eoi_n = 1'b1;
        atn_n = 1'b1;
        wait_bus("talk_rdy_wait", 1'b0, 1'b0);
    endtask

    // Monitor: compare every byte the consumer takes against the scoreboard
    always @(negedge clk) begin
        #1;
        if (!rst && rx_valid && rx_ready) begin
            n_rx++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rx_unexpected: got %0h expected no byte", {rx_data, rx_eoi, rx_atn});
            end else begin
                rx_t e;
                e = exp_q.pop_front();
                chk("rx_byte", {22'd0, rx_data, rx_eoi, rx_atn}, {22'd0, e});
            end
        end
    end

    initial begin
        int cnt;
        int cnt2;
        int rx_before;
        rst = 1'b1; listen = 1'b0; dav_n = 1'b1; eoi_n = 1'b1; atn_n = 1'b1;
        dio_n = 8'hFF; rx_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_bus", {30'd0, nrfd_n, ndac_n}, 32'd3);
        chk("reset_rx", {21'd0, rx_valid, rx_data, rx_eoi, rx_atn, err_timeout}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_bus", {30'd0, nrfd_n, ndac_n}, 32'd3);

        // Basic 3-wire byte 0x41 with EOI
        listen = 1'b1;
        wait_bus("rdy_wait0", 1'b0, 1'b0);
        rx_before = n_rx;
        send_byte(8'hBE, 1'b0, 1'b1);
        wait_bus("ready_after", 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        chk("one_pulse", n_rx - rx_before, 32'd1);

        // Consumer stalled: second byte must wait until first is popped
        rx_ready = 1'b0;
        send_byte(8'hEC, 1'b1, 1'b0);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (nrfd_n !== 1'b0) cnt++;
        end
        chk("nrfd_held", cnt, 32'd0);
        chk("held_valid", {31'd0, rx_valid}, 32'd1);
        rx_ready = 1'b1;
        send_byte(8'h5A, 1'b1, 1'b1);
        wait_bus("ready_after2", 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);

        // listen dropped in CAPTURE: byte discarded
        rx_before = n_rx;
        dio_n = 8'h00;
        dav_n = 1'b0;
        wait_bus("cap_drop", 1'b0, 1'b0);
        listen = 1'b0;
        @(negedge clk);
        chk("drop_bus", {30'd0, nrfd_n, ndac_n}, 32'd3);
        chk("drop_valid", {31'd0, rx_valid}, 32'd0);
        repeat (5) @(negedge clk);
        chk("drop_valid_late", {31'd0, rx_valid}, 32'd0);
        dav_n = 1'b1;
        dio_n = 8'hFF;
        listen = 1'b1;
        wait_bus("drop_ready", 1'b1, 1'b0);
        chk("drop_no_rx", n_rx - rx_before, 32'd0);

        // Short DAV glitch: capture aborted, back to READY
        @(negedge clk);
        dav_n = 1'b0;
        @(negedge clk);
        dav_n = 1'b1;
        wait_bus("glitch_cap", 1'b0, 1'b0);
        wait_bus("glitch_ready", 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        chk("glitch_valid", {31'd0, rx_valid}, 32'd0);
        chk("glitch_no_rx", n_rx - rx_before, 32'd0);

        // DAV held low in ACCEPT
        dio_n = 8'h33;
        exp_q.push_back('{data: 8'hCC, eoi: 1'b0, atn: 1'b0});
        dav_n = 1'b0;
        wait_bus("tmo_accept", 1'b0, 1'b1);
`ifdef GPIB_ACCEPTOR_TIMEOUT_EN
        cnt = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (err_timeout === 1'b1 && cnt == 0) begin
                cnt = i;
                chk("tmo_rdy_wait", {30'd0, nrfd_n, ndac_n}, 32'd0);
            end
        end
        chk("tmo_cycle", cnt, 32'd16);
`else
        cnt = 0;
        cnt2 = 0;
        repeat (40) begin
            @(negedge clk);
            if (err_timeout !== 1'b0) cnt++;
            if (nrfd_n !== 1'b0 || ndac_n !== 1'b1) cnt2++;
        end
        chk("no_tmo_err", cnt, 32'd0);
        chk("no_tmo_stay", cnt2, 32'd0);
`endif
        dav_n = 1'b1;
        dio_n = 8'hFF;
        wait_bus("tmo_ready", 1'b1, 1'b0);

        // Reset in ACCEPT with a byte held
        rx_ready = 1'b0;
        dio_n = 8'h0F;
        dav_n = 1'b0;
        wait_bus("rst_accept", 1'b0, 1'b1);
        chk("rst_pre_valid", {31'd0, rx_valid}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_bus", {30'd0, nrfd_n, ndac_n}, 32'd3);
        chk("rst_rx", {21'd0, rx_valid, rx_data, rx_eoi, rx_atn, err_timeout}, 32'd0);
        rst = 1'b0;
        dav_n = 1'b1;
        dio_n = 8'hFF;
        rx_ready = 1'b1;
        wait_bus("rst_ready", 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        chk("final_queue", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
